hilo_md_ctrl: RTL and testbench

- Sequencing controller for the HI/LO multiply/divide unit of the MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO from EX. It launches the fixed-latency multiplier or the iterative divider, and routes multiplier results through the HI/LO accumulate adder (MCalc) for MADD/MSUB.
- Owns the architectural HI/LO registers and stalls the pipeline on hazards.

---
 rtl/hilo_md_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_hilo_md_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: sequencing controller for the HI/LO multiply/divide unit.
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO (SPECIAL) and MADD/MADDU/MSUB/MSUBU
// (SPECIAL2) from EX while idle. It launches the fixed-latency multiplier or
// the iterative divider, routes MADD-family products through the external
// accumulate adder (MCalc), and owns the architectural HI/LO registers.
//
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_start, i_sp2, i_func         md op request and its opcode/function
//   i_rs, i_rt                     operands
//   i_read                         MFHI/MFLO in EX
//   o_stall, o_busy                pipeline hold / controller not idle
//   o_mul_*, i_mul_hi/lo           multiplier launch, operands, product
//   o_div_*, i_div_*               divider launch, operands, result
//   o_mc_*, i_mc_hi/lo             MCalc function, operands, result
//   o_hi, o_lo                     architectural HI/LO
module hilo_md_ctrl #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_sp2,
  input  logic [5:0]  i_func,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic        i_read,
  output logic        o_stall,
  output logic        o_busy,
  output logic        o_mul_start,
  output logic        o_mul_signed,
  output logic [31:0] o_mul_a,
  output logic [31:0] o_mul_b,
  input  logic [31:0] i_mul_hi,
  input  logic [31:0] i_mul_lo,
  output logic        o_div_start,
  output logic        o_div_signed,
  output logic [31:0] o_div_a,
  output logic [31:0] o_div_b,
  input  logic        i_div_done,
  input  logic [31:0] i_div_quot,
  input  logic [31:0] i_div_rem,
  output logic [5:0]  o_mc_func,
  output logic [31:0] o_mc_mult_hi,
  output logic [31:0] o_mc_mult_lo,
  output logic [31:0] o_mc_reg_hi,
  output logic [31:0] o_mc_reg_lo,
  input  logic [31:0] i_mc_hi,
  input  logic [31:0] i_mc_lo,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, ACC, DIV_WAIT} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        acc_q;        // current multiply feeds MCalc (MADD family)
  logic [5:0]  func_q;
  logic [31:0] hi_q, lo_q;
  logic        mul_start_q, mul_signed_q;
  logic [31:0] mul_a_q, mul_b_q;
  logic        div_start_q, div_signed_q;
  logic [31:0] div_a_q, div_b_q;
  logic [31:0] mc_mult_hi_q, mc_mult_lo_q;

  // Opcode decode; only meaningful together with i_start in IDLE.
  logic dec_mul, dec_madd, dec_div, dec_mthi, dec_mtlo, dec_signed;

  always_comb begin
    dec_mul    = 1'b0;
    dec_madd   = 1'b0;
    dec_div    = 1'b0;
    dec_mthi   = 1'b0;
    dec_mtlo   = 1'b0;
    dec_signed = 1'b0;
    if (!i_sp2) begin
      case (i_func)
        6'h18: begin dec_mul = 1'b1; dec_signed = 1'b1; end
        6'h19: dec_mul = 1'b1;
        6'h1A: begin dec_div = 1'b1; dec_signed = 1'b1; end
        6'h1B: dec_div = 1'b1;
        6'h11: dec_mthi = 1'b1;
        6'h13: dec_mtlo = 1'b1;
        default: ;
      endcase
    end else begin
      case (i_func)
        6'h00: begin dec_madd = 1'b1; dec_signed = 1'b1; end
        6'h01: dec_madd = 1'b1;
        6'h04: begin dec_madd = 1'b1; dec_signed = 1'b1; end
        6'h05: dec_madd = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      func_q       <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mul_start_q  <= 1'b0;
      mul_signed_q <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      div_start_q  <= 1'b0;
      div_signed_q <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      mc_mult_hi_q <= '0;
      mc_mult_lo_q <= '0;
    end else begin
      // Launch strobes are single-cycle unless re-armed below.
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            if (dec_mthi) hi_q <= i_rs;
            if (dec_mtlo) lo_q <= i_rs;
            if (dec_mul || dec_madd) begin
              mul_a_q      <= i_rs;
              mul_b_q      <= i_rt;
              mul_signed_q <= dec_signed;
              func_q       <= i_func;
              acc_q        <= dec_madd;
              cnt_q        <= 4'(MUL_LAT);
              mul_start_q  <= 1'b1;
              state_q      <= MUL_WAIT;
            end
            // Divide by zero is architecturally undefined: leave HI/LO alone
            // and never start the divider.
            if (dec_div && (i_rt != 32'd0)) begin
              div_a_q      <= i_rs;
              div_b_q      <= i_rt;
              div_signed_q <= dec_signed;
              div_start_q  <= 1'b1;
              state_q      <= DIV_WAIT;
            end
          end
        end
        MUL_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          // Counter holds MUL_LAT in the launch cycle, so it reads 1 in the
          // cycle the multiplier output is valid.
          if (cnt_q == 4'd1) begin
            if (acc_q) begin
              mc_mult_hi_q <= i_mul_hi;
              mc_mult_lo_q <= i_mul_lo;
              state_q      <= ACC;
            end else begin
              hi_q    <= i_mul_hi;
              lo_q    <= i_mul_lo;
              state_q <= IDLE;
            end
          end
        end
        ACC: begin
          hi_q    <= i_mc_hi;
          lo_q    <= i_mc_lo;
          state_q <= IDLE;
        end
        DIV_WAIT: begin
          if (i_div_done) begin
            hi_q    <= i_div_rem;
            lo_q    <= i_div_quot;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy       = (state_q != IDLE);
  // No bypass: anything touching HI/LO waits until the op has retired.
  assign o_stall      = o_busy & (i_start | i_read);

  assign o_mul_start  = mul_start_q;
  assign o_mul_signed = mul_signed_q;
  assign o_mul_a      = mul_a_q;
  assign o_mul_b      = mul_b_q;

  assign o_div_start  = div_start_q;
  assign o_div_signed = div_signed_q;
  assign o_div_a      = div_a_q;
  assign o_div_b      = div_b_q;

  assign o_mc_func    = func_q;
  assign o_mc_mult_hi = mc_mult_hi_q;
  assign o_mc_mult_lo = mc_mult_lo_q;
  assign o_mc_reg_hi  = hi_q;
  assign o_mc_reg_lo  = lo_q;

  assign o_hi         = hi_q;
  assign o_lo         = lo_q;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
module tb_hilo_md_ctrl;
  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_sp2, i_read;
  logic [5:0]  i_func;
  logic [31:0] i_rs, i_rt;
  logic        o_stall, o_busy;
  logic        o_mul_start, o_mul_signed;
  logic [31:0] o_mul_a, o_mul_b, i_mul_hi, i_mul_lo;
  logic        o_div_start, o_div_signed, i_div_done;
  logic [31:0] o_div_a, o_div_b, i_div_quot, i_div_rem;
  logic [5:0]  o_mc_func;
  logic [31:0] o_mc_mult_hi, o_mc_mult_lo, o_mc_reg_hi, o_mc_reg_lo;
  logic [31:0] i_mc_hi, i_mc_lo, o_hi, o_lo;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  hilo_md_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_sp2(i_sp2),
    .i_func(i_func), .i_rs(i_rs), .i_rt(i_rt), .i_read(i_read),
    .o_stall(o_stall), .o_busy(o_busy),
    .o_mul_start(o_mul_start), .o_mul_signed(o_mul_signed),
    .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
    .i_mul_hi(i_mul_hi), .i_mul_lo(i_mul_lo),
    .o_div_start(o_div_start), .o_div_signed(o_div_signed),
    .o_div_a(o_div_a), .o_div_b(o_div_b),
    .i_div_done(i_div_done), .i_div_quot(i_div_quot), .i_div_rem(i_div_rem),
    .o_mc_func(o_mc_func), .o_mc_mult_hi(o_mc_mult_hi),
    .o_mc_mult_lo(o_mc_mult_lo), .o_mc_reg_hi(o_mc_reg_hi),
    .o_mc_reg_lo(o_mc_reg_lo), .i_mc_hi(i_mc_hi), .i_mc_lo(i_mc_lo),
    .o_hi(o_hi), .o_lo(o_lo)
  );

  // Multiplier model: product valid only in the cycle MUL_LAT-1 cycles after
  // the launch cycle; garbage otherwise so mistimed sampling shows up.
  int mcnt = 100;
  logic [63:0] prod;
  always @(posedge clk) begin
    if (o_mul_start) mcnt <= 1;
    else if (mcnt < 100) mcnt <= mcnt + 1;
  end
  always_comb begin
    if (o_mul_signed)
      prod = $signed({{32{o_mul_a[31]}}, o_mul_a}) * $signed({{32{o_mul_b[31]}}, o_mul_b});
    else
      prod = {32'd0, o_mul_a} * {32'd0, o_mul_b};
  end
  assign {i_mul_hi, i_mul_lo} = (mcnt == MUL_LAT - 1) ? prod : 64'hDEAD_BEEF_DEAD_BEEF;

  // MCalc model: 64-bit accumulate / subtract from HI:LO.
  assign {i_mc_hi, i_mc_lo} = o_mc_func[2] ? ({o_mc_reg_hi, o_mc_reg_lo} - {o_mc_mult_hi, o_mc_mult_lo})
                                           : ({o_mc_reg_hi, o_mc_reg_lo} + {o_mc_mult_hi, o_mc_mult_lo});

  // Drive an op for one accepted edge; returns at the negedge of cycle T+1.
  task automatic issue(input logic sp2, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    i_start = 1'b1; i_sp2 = sp2; i_func = f; i_rs = a; i_rt = b;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_start = 0; i_sp2 = 0; i_func = 0; i_rs = 0; i_rt = 0; i_read = 0;
    i_div_done = 0; i_div_quot = 32'hBAD0BAD0; i_div_rem = 32'hBAD0BAD0;
    @(negedge clk); @(negedge clk);
    vec++; if ({o_hi, o_lo} !== 64'd0) begin err++; $display("FAIL reset_hilo got %h exp 0", {o_hi, o_lo}); end
    vec++; if ({o_busy, o_stall, o_mul_start, o_div_start} !== 4'd0) begin err++; $display("FAIL reset_ctl got %b exp 0000", {o_busy, o_stall, o_mul_start, o_div_start}); end
    vec++; if ({o_mul_a, o_mul_b, o_div_a, o_div_b, o_mc_func, o_mc_mult_lo} !== '0) begin err++; $display("FAIL reset_regs got nonzero exp 0"); end
    i_rst = 1'b0;
  endtask

  task automatic test_reset_midop;
    issue(0, 6'h11, 32'h1234, 0);              // MTHI
    vec++; if (o_hi !== 32'h1234 || o_busy !== 1'b0) begin err++; $display("FAIL mthi got hi=%h busy=%b exp 1234/0", o_hi, o_busy); end
    issue(0, 6'h18, 32'd3, 32'd4);             // MULT, now in MUL_WAIT
    i_rst = 1'b1; i_read = 1'b1;
    @(negedge clk); i_rst = 1'b0;
    vec++; if ({o_busy, o_stall} !== 2'b00 || {o_hi, o_lo} !== 64'd0) begin err++; $display("FAIL rst_mul got busy=%b stall=%b hilo=%h exp 0", o_busy, o_stall, {o_hi, o_lo}); end
    repeat (3) @(negedge clk);
    vec++; if ({o_hi, o_lo} !== 64'd0 || o_busy !== 1'b0) begin err++; $display("FAIL rst_mul_late got hilo=%h exp 0", {o_hi, o_lo}); end
    issue(0, 6'h1B, 32'd9, 32'd2);             // DIVU, now in DIV_WAIT
    i_rst = 1'b1;
    @(negedge clk); i_rst = 1'b0;
    i_div_done = 1'b1; i_div_quot = 32'd4; i_div_rem = 32'd1;
    @(negedge clk); i_div_done = 1'b0; i_div_quot = 32'hBAD0BAD0; i_div_rem = 32'hBAD0BAD0;
    i_read = 1'b0;
    vec++; if ({o_hi, o_lo} !== 64'd0 || o_busy !== 1'b0) begin err++; $display("FAIL rst_div_late got hilo=%h busy=%b exp 0/0", {o_hi, o_lo}, o_busy); end
    issue(0, 6'h13, 32'd5, 0);                 // MTLO 5
    vec++; if (o_lo !== 32'd5 || o_hi !== 32'd0) begin err++; $display("FAIL mtlo_after_rst got lo=%h hi=%h exp 5/0", o_lo, o_hi); end
  endtask

  task automatic test_mult;
    issue(0, 6'h18, 32'hFFFF_FFFF, 32'd2);
    vec++; if ({o_mul_start, o_mul_signed, o_busy} !== 3'b111) begin err++; $display("FAIL mult_launch got %b exp 111", {o_mul_start, o_mul_signed, o_busy}); end
    vec++; if (o_mul_a !== 32'hFFFF_FFFF || o_mul_b !== 32'd2) begin err++; $display("FAIL mult_ops got %h %h exp ffffffff 2", o_mul_a, o_mul_b); end
    for (int k = 2; k <= MUL_LAT; k++) begin
      @(negedge clk);
      vec++; if ({o_mul_start, o_busy} !== 2'b01) begin err++; $display("FAIL mult_wait%0d got start=%b busy=%b exp 0/1", k, o_mul_start, o_busy); end
    end
    @(negedge clk);
    vec++; if (o_busy !== 1'b0) begin err++; $display("FAIL mult_done_busy got %b exp 0", o_busy); end
    vec++; if ({o_hi, o_lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin err++; $display("FAIL mult_result got %h exp fffffffffffffffe", {o_hi, o_lo}); end
  endtask

  task automatic test_stall_start;
    // MULTU 3*5 with an MTLO held at EX while busy: must stall, not be taken.
    issue(0, 6'h19, 32'd3, 32'd5);
    vec++; if (o_mul_signed !== 1'b0) begin err++; $display("FAIL multu_signed got %b exp 0", o_mul_signed); end
    i_start = 1'b1; i_func = 6'h13; i_rs = 32'h7777;
    #1;
    vec++; if (o_stall !== 1'b1) begin err++; $display("FAIL busy_start_stall got %b exp 1", o_stall); end
    @(negedge clk); @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    vec++; if ({o_hi, o_lo} !== 64'd15 || o_stall !== 1'b0) begin err++; $display("FAIL multu_result got %h stall=%b exp 15/0", {o_hi, o_lo}, o_stall); end
  endtask

  task automatic test_maddu;
    issue(0, 6'h11, 32'd0, 0);
    issue(0, 6'h13, 32'd10, 0);
    issue(1, 6'h01, 32'd3, 32'd4);
    @(negedge clk); @(negedge clk); @(negedge clk);   // ACC cycle
    vec++; if (o_mc_func !== 6'h01 || o_mc_reg_lo !== 32'd10 || o_mc_mult_lo !== 32'd12 || o_busy !== 1'b1) begin
      err++; $display("FAIL maddu_acc got func=%h reg_lo=%h mult_lo=%h busy=%b exp 01/a/c/1", o_mc_func, o_mc_reg_lo, o_mc_mult_lo, o_busy); end
    @(negedge clk);
    vec++; if ({o_hi, o_lo} !== 64'd22 || o_busy !== 1'b0) begin err++; $display("FAIL maddu_result got %h busy=%b exp 22/0", {o_hi, o_lo}, o_busy); end
  endtask

  task automatic test_msubu;
    issue(0, 6'h11, 32'd0, 0);
    issue(0, 6'h13, 32'd5, 0);
    issue(1, 6'h05, 32'd1, 32'd6);
    repeat (MUL_LAT + 1) @(negedge clk);
    vec++; if ({o_hi, o_lo} !== 64'hFFFF_FFFF_FFFF_FFFF || o_busy !== 1'b0) begin err++; $display("FAIL msubu_result got %h busy=%b exp ffffffffffffffff/0", {o_hi, o_lo}, o_busy); end
  endtask

  task automatic test_divu;
    int bad;
    i_read = 1'b1;
    issue(0, 6'h1B, 32'd7, 32'd2);
    vec++; if ({o_div_start, o_div_signed, o_stall} !== 3'b101 || o_div_a !== 32'd7 || o_div_b !== 32'd2) begin
      err++; $display("FAIL divu_launch got start=%b signed=%b stall=%b a=%h b=%h exp 1/0/1/7/2", o_div_start, o_div_signed, o_stall, o_div_a, o_div_b); end
    bad = 0;
    for (int k = 2; k <= 33; k++) begin
      @(negedge clk);
      if (o_stall !== 1'b1 || o_div_start !== 1'b0) bad++;
    end
    vec++; if (bad != 0) begin err++; $display("FAIL divu_wait_stall got %0d bad cycles exp 0", bad); end
    i_div_done = 1'b1; i_div_quot = 32'd3; i_div_rem = 32'd1;
    @(negedge clk);
    i_div_done = 1'b0; i_div_quot = 32'hBAD0BAD0; i_div_rem = 32'hBAD0BAD0;
    vec++; if (o_lo !== 32'd3 || o_hi !== 32'd1 || o_stall !== 1'b0) begin err++; $display("FAIL divu_result got hi=%h lo=%h stall=%b exp 1/3/0", o_hi, o_lo, o_stall); end
    i_read = 1'b0;
  endtask

  task automatic test_div0;
    int bad;
    issue(0, 6'h1A, 32'd100, 32'd0);
    vec++; if ({o_div_start, o_busy} !== 2'b00) begin err++; $display("FAIL div0_launch got start=%b busy=%b exp 0/0", o_div_start, o_busy); end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_busy !== 1'b0 || o_div_start !== 1'b0) bad++;
    end
    vec++; if (bad != 0 || o_hi !== 32'd1 || o_lo !== 32'd3) begin err++; $display("FAIL div0_hilo got hi=%h lo=%h bad=%0d exp 1/3/0", o_hi, o_lo, bad); end
    i_div_done = 1'b1; i_div_quot = 32'h55; i_div_rem = 32'h66;
    @(negedge clk);
    i_div_done = 1'b0;
    @(negedge clk);
    vec++; if (o_hi !== 32'd1 || o_lo !== 32'd3 || o_busy !== 1'b0) begin err++; $display("FAIL stray_done got hi=%h lo=%h busy=%b exp 1/3/0", o_hi, o_lo, o_busy); end
  endtask

  initial begin
    test_reset;
    test_reset_midop;
    test_mult;
    test_stall_start;
    test_maddu;
    test_msubu;
    test_divu;
    test_div0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
